merlin_mem_arbiter: RTL and testbench
=====================================

// Module: merlin_mem_arbiter
// PURPOSE
//  Shares one memory port between instruction fetch (I) and the load/store queue (D).
//  Each cycle it grants one requester, passes that request straight through to the memory port,
//  and logs the requester ID of every accepted read.
//  Read responses are routed back to the requester at the head of that log (strictly in order).
//  Write-error responses always go to D.
// PARAMETERS
//  C_ARB_MODE        0     0 = round-robin, 1 = fixed priority to D
//  C_ORDER_DEPTH_X   2     log2 depth of the outstanding-read order FIFO
// PORTS
//  clk_i          in   1      clock; single clock domain
//  clk_en_i       in   1      clock enable; state/FIFO update only when high
//  reset_i        in   1      synchronous, active-high reset
//  ireqready_o    out  1      I request accepted
//  ireqvalid_i    in   1      I request valid (always read, size word)
//  ireqhpl_i      in   2      I privilege level
//  ireqaddr_i     in   XLEN   I address
//  irspready_i    in   1      I can take response
//  irspvalid_o    out  1      I response valid
//  irsprerr_o     out  1      I read access error
//  irspdata_o     out  XLEN   I response data
//  dreqready_o    out  1      D request accepted
//  dreqvalid_i    in   1      D request valid
//  dreqsize_i     in   2      D size (funct3[1:0])
//  dreqwrite_i    in   1      D write
//  dreqhpl_i      in   2      D privilege level
//  dreqaddr_i     in   XLEN   D address
//  dreqdata_i     in   XLEN   D write data (pre-justified)
//  drspready_i    in   1      D can take response
//  drspvalid_o    out  1      D response valid
//  drsprerr_o     out  1      D read error
//  drspwerr_o     out  1      D write error
//  drspdata_o     out  XLEN   D response data
//  mreqready_i    in   1      memory accepts request
//  mreqvalid_o    out  1      memory request valid
//  mreqsize_o / mreqwrite_o / mreqhpl_o / mreqaddr_o / mreqdata_o   out  2/1/2/XLEN/XLEN   muxed request
//  mrspready_o    out  1      response consumed
//  mrspvalid_i    in   1      memory response valid
//  mrsprerr_i / mrspwerr_i    in   1/1   read / write error
//  mrspdata_i     in   XLEN   response data
// BEHAVIOUR
//  - While reset_i=1: all valid/ready outputs are 0. Registers clear: lock=0, gnt=I, last=I (D wins the first tie), order FIFO empty.
//  - Request path is zero latency: mreq* = granted requester's fields. For I: size=2'b10, write=0, data=0.
//  - mreqvalid_o = granted valid & ~order_full. An I request, or a D read, counts as a read.
//    - A D write is not blocked by order_full.
//  - x_reqready_o = mreqready_i & mreqvalid_o & (gnt==x).
//  - Grant FSM:
//    - UNLOCKED: gnt is combinational. Only one valid -> grant it. Both valid -> mode 0 grants the one not equal to last; mode 1 grants D.
//    - UNLOCKED -> LOCKED when mreqvalid_o=1 & mreqready_i=0; gnt is registered.
//    - LOCKED: gnt is held and the requester must hold its request stable. LOCKED -> UNLOCKED on handshake.
//    - On every handshake: last <= gnt.
//  - Order FIFO push: handshake & read, pushing gnt ID. Push and pop may occur in the same cycle; full/empty flags are taken before the update.
//  - Response routing:
//    - mrspwerr_i=1 -> route to D, no pop.
//    - Otherwise -> route to order-FIFO head, pop on mrspvalid_i & mrspready_o.
//    - mrspready_o = mrspvalid_i & (routed target's rspready).
//    - x_rspvalid_o = mrspvalid_i & routed==x. Data and error flags are broadcast to both ports.
//  - mrspvalid_i with an empty FIFO and no werr: protocol error. Assert in simulation; the response is dropped (mrspready_o=1).
//  - Response to I with mrspwerr_i=1 is impossible by construction.
//  - clk_en_i=0: no state change. Combinational outputs still track inputs.
// STRUCTURE
//  - Shared include (riscv_defs.v): `MERLIN_ARB_ID_I 1'b0, `MERLIN_ARB_ID_D 1'b1, `MERLIN_ARB_RR 0, `MERLIN_ARB_FIXED 1.
//  - Sub-module: merlin_fifo (width 1, depth 2^C_ORDER_DEPTH_X, flush tied 0) as the order FIFO.
//  - Grant FSM and response mux live in this module.
// TESTING
//  1 Both valid every cycle, mreqready_i=1, mode 0 -> grants alternate D,I,D,I; reqready pulses interleave.
//  2 D valid, mreqready_i=0 for 3 cycles, I raises valid in cycle 2 -> gnt stays D (LOCKED); I granted the cycle after D's handshake.
//  3 Issue 4 I reads with depth 4 and no responses -> 5th I: mreqvalid_o=0. A D write still passes. Responses return to I in order.
//  4 Interleave I read, D read, I read; responses 0xA,0xB,0xC -> irsp 0xA, drsp 0xB, irsp 0xC. Stall irspready_i -> mrspready_o=0.
//  5 Response with mrspwerr_i=1 while FIFO head=I -> drspvalid_o=1, drspwerr_o=1; head unchanged.
//  6 Assert reset_i mid-LOCKED with 2 reads outstanding -> next cycle: outputs 0, FIFO empty, UNLOCKED, and a D-vs-I tie grants D.

Source files
------------

// File: rtl/merlin_mem_arbiter_pkg.sv
// Shared definitions for the merlin memory arbiter.
//   Requester IDs, arbitration mode encodings and the grant FSM state type.
package merlin_mem_arbiter_pkg;

   // Requester IDs as stored in the outstanding-read order FIFO
   localparam logic ID_I = 1'b0;
   localparam logic ID_D = 1'b1;

   // Arbitration modes
   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   typedef enum logic {
      StUnlocked,
      StLocked
   } arb_state_e;

endpackage

// File: rtl/merlin_fifo.sv
// Synchronous FIFO with 2^DEPTH_X entries.
//   clk/clk_en/reset : clock, clock enable, synchronous active-high reset
//   flush            : synchronous clear of all entries
//   push/wdata       : write side (ignored when full)
//   pop/rdata        : read side, rdata is the current head (ignored when empty)
//   full/empty       : occupancy flags for the current cycle
module merlin_fifo #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned DEPTH_X = 2
) (
   input  logic             clk,
   input  logic             clk_en,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_X;

   // One extra pointer bit distinguishes full from empty
   logic [DEPTH_X:0]   wr_ptr;
   logic [DEPTH_X:0]   rd_ptr;
   logic [WIDTH-1:0]   mem [DEPTH];
   logic               do_push;
   logic               do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_X] != rd_ptr[DEPTH_X]) &&
                    (wr_ptr[DEPTH_X-1:0] == rd_ptr[DEPTH_X-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr[DEPTH_X-1:0]];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clk_en) begin
         if (do_push) begin
            mem[wr_ptr[DEPTH_X-1:0]] <= wdata;
            wr_ptr                   <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/merlin_mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and the load/store queue (D).
//   ireq*/irsp* : I request (always word read) and response channels
//   dreq*/drsp* : D request (read or write) and response channels
//   mreq*/mrsp* : shared memory request and response channels
//   clk_i/clk_en_i/reset_i : clock, clock enable, synchronous active-high reset
// Requests pass through combinationally; the ID of every accepted read is logged so
// read responses can be steered back in order. Write errors always go to D.
module merlin_mem_arbiter
   import merlin_mem_arbiter_pkg::*;
#(
   parameter int unsigned C_ARB_MODE      = ARB_RR,
   parameter int unsigned C_ORDER_DEPTH_X = 2,
   parameter int unsigned XLEN            = 32
) (
   input  logic            clk_i,
   input  logic            clk_en_i,
   input  logic            reset_i,
   output logic            ireqready_o,
   input  logic            ireqvalid_i,
   input  logic [1:0]      ireqhpl_i,
   input  logic [XLEN-1:0] ireqaddr_i,
   input  logic            irspready_i,
   output logic            irspvalid_o,
   output logic            irsprerr_o,
   output logic [XLEN-1:0] irspdata_o,
   output logic            dreqready_o,
   input  logic            dreqvalid_i,
   input  logic [1:0]      dreqsize_i,
   input  logic            dreqwrite_i,
   input  logic [1:0]      dreqhpl_i,
   input  logic [XLEN-1:0] dreqaddr_i,
   input  logic [XLEN-1:0] dreqdata_i,
   input  logic            drspready_i,
   output logic            drspvalid_o,
   output logic            drsprerr_o,
   output logic            drspwerr_o,
   output logic [XLEN-1:0] drspdata_o,
   input  logic            mreqready_i,
   output logic            mreqvalid_o,
   output logic [1:0]      mreqsize_o,
   output logic            mreqwrite_o,
   output logic [1:0]      mreqhpl_o,
   output logic [XLEN-1:0] mreqaddr_o,
   output logic [XLEN-1:0] mreqdata_o,
   output logic            mrspready_o,
   input  logic            mrspvalid_i,
   input  logic            mrsprerr_i,
   input  logic            mrspwerr_i,
   input  logic [XLEN-1:0] mrspdata_i
);

   arb_state_e state;
   logic       gnt;
   logic       gnt_q;
   logic       last_q;
   logic       gnt_valid;
   logic       gnt_read;
   logic       handshake;
   logic       order_full;
   logic       order_empty;
   logic       order_head;
   logic       order_push;
   logic       order_pop;
   logic       rsp_to_i;
   logic       rsp_to_d;
   logic       rsp_drop;
   logic       target_ready;

   // Grant: held while locked, otherwise decided this cycle
   always_comb begin
      if (state == StLocked) begin
         gnt = gnt_q;
      end else if (ireqvalid_i && dreqvalid_i) begin
         gnt = (C_ARB_MODE == ARB_FIXED) ? ID_D : ~last_q;
      end else if (dreqvalid_i) begin
         gnt = ID_D;
      end else begin
         gnt = ID_I;
      end
   end

   // Request mux; I is always a word read with no data
   always_comb begin
      if (gnt == ID_D) begin
         gnt_valid   = dreqvalid_i;
         gnt_read    = ~dreqwrite_i;
         mreqsize_o  = dreqsize_i;
         mreqwrite_o = dreqwrite_i;
         mreqhpl_o   = dreqhpl_i;
         mreqaddr_o  = dreqaddr_i;
         mreqdata_o  = dreqdata_i;
      end else begin
         gnt_valid   = ireqvalid_i;
         gnt_read    = 1'b1;
         mreqsize_o  = 2'b10;
         mreqwrite_o = 1'b0;
         mreqhpl_o   = ireqhpl_i;
         mreqaddr_o  = ireqaddr_i;
         mreqdata_o  = '0;
      end
   end

   // Only reads need an order-log slot, so writes bypass the full check
   assign mreqvalid_o = ~reset_i & gnt_valid & ~(order_full & gnt_read);
   assign handshake   = mreqvalid_o & mreqready_i;
   assign ireqready_o = handshake & (gnt == ID_I);
   assign dreqready_o = handshake & (gnt == ID_D);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state  <= StUnlocked;
         gnt_q  <= ID_I;
         last_q <= ID_I;
      end else if (clk_en_i) begin
         if (handshake) begin
            last_q <= gnt;
         end
         case (state)
            StUnlocked: begin
               // Stalled request: freeze the grant until the handshake
               if (mreqvalid_o && !mreqready_i) begin
                  state <= StLocked;
                  gnt_q <= gnt;
               end
            end
            StLocked: begin
               if (handshake) begin
                  state <= StUnlocked;
               end
            end
            default: state <= StUnlocked;
         endcase
      end
   end

   assign order_push = clk_en_i & handshake & gnt_read;

   merlin_fifo #(
      .WIDTH   (1),
      .DEPTH_X (C_ORDER_DEPTH_X)
   ) u_order_fifo (
      .clk    (clk_i),
      .clk_en (clk_en_i),
      .reset  (reset_i),
      .flush  (1'b0),
      .push   (order_push),
      .wdata  (gnt),
      .pop    (order_pop),
      .rdata  (order_head),
      .full   (order_full),
      .empty  (order_empty)
   );

   // Response routing; a read response with nothing outstanding is swallowed
   assign rsp_to_d = mrspwerr_i | (~order_empty & (order_head == ID_D));
   assign rsp_to_i = ~mrspwerr_i & ~order_empty & (order_head == ID_I);
   assign rsp_drop = ~mrspwerr_i & order_empty;

   always_comb begin
      if (rsp_drop) begin
         target_ready = 1'b1;
      end else if (rsp_to_d) begin
         target_ready = drspready_i;
      end else begin
         target_ready = irspready_i;
      end
   end

   assign mrspready_o = ~reset_i & mrspvalid_i & target_ready;
   assign irspvalid_o = ~reset_i & mrspvalid_i & rsp_to_i;
   assign drspvalid_o = ~reset_i & mrspvalid_i & rsp_to_d;
   assign order_pop   = clk_en_i & mrspready_o & ~mrspwerr_i & ~order_empty;

   assign irsprerr_o = mrsprerr_i;
   assign irspdata_o = mrspdata_i;
   assign drsprerr_o = mrsprerr_i;
   assign drspwerr_o = mrspwerr_i;
   assign drspdata_o = mrspdata_i;

   a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (reset_i)
      (clk_en_i && mrspvalid_i && !mrspwerr_i) |-> !order_empty)
      else $error("merlin_mem_arbiter: read response with no outstanding read");

endmodule

// File: tb/tb_merlin_mem_arbiter.sv
// Directed bench for merlin_mem_arbiter in round-robin mode with a 4-entry order FIFO.
module tb_merlin_mem_arbiter;

   logic        clk = 1'b0;
   logic        clk_en;
   logic        reset;
   logic        ireqready, ireqvalid, irspready, irspvalid, irsprerr;
   logic [1:0]  ireqhpl;
   logic [31:0] ireqaddr, irspdata;
   logic        dreqready, dreqvalid, dreqwrite, drspready, drspvalid, drsprerr, drspwerr;
   logic [1:0]  dreqsize, dreqhpl;
   logic [31:0] dreqaddr, dreqdata, drspdata;
   logic        mreqready, mreqvalid, mreqwrite, mrspready, mrspvalid, mrsprerr, mrspwerr;
   logic [1:0]  mreqsize, mreqhpl;
   logic [31:0] mreqaddr, mreqdata, mrspdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   merlin_mem_arbiter #(
      .C_ARB_MODE      (0),
      .C_ORDER_DEPTH_X (2),
      .XLEN            (32)
   ) dut (
      .clk_i       (clk),
      .clk_en_i    (clk_en),
      .reset_i     (reset),
      .ireqready_o (ireqready),
      .ireqvalid_i (ireqvalid),
      .ireqhpl_i   (ireqhpl),
      .ireqaddr_i  (ireqaddr),
      .irspready_i (irspready),
      .irspvalid_o (irspvalid),
      .irsprerr_o  (irsprerr),
      .irspdata_o  (irspdata),
      .dreqready_o (dreqready),
      .dreqvalid_i (dreqvalid),
      .dreqsize_i  (dreqsize),
      .dreqwrite_i (dreqwrite),
      .dreqhpl_i   (dreqhpl),
      .dreqaddr_i  (dreqaddr),
      .dreqdata_i  (dreqdata),
      .drspready_i (drspready),
      .drspvalid_o (drspvalid),
      .drsprerr_o  (drsprerr),
      .drspwerr_o  (drspwerr),
      .drspdata_o  (drspdata),
      .mreqready_i (mreqready),
      .mreqvalid_o (mreqvalid),
      .mreqsize_o  (mreqsize),
      .mreqwrite_o (mreqwrite),
      .mreqhpl_o   (mreqhpl),
      .mreqaddr_o  (mreqaddr),
      .mreqdata_o  (mreqdata),
      .mrspready_o (mrspready),
      .mrspvalid_i (mrspvalid),
      .mrsprerr_i  (mrsprerr),
      .mrspwerr_i  (mrspwerr),
      .mrspdata_i  (mrspdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset     = 1'b0;
      clk_en    = 1'b1;
      ireqvalid = 1'b0;
      ireqhpl   = 2'b11;
      ireqaddr  = 32'h0;
      irspready = 1'b1;
      dreqvalid = 1'b0;
      dreqsize  = 2'b10;
      dreqwrite = 1'b1;
      dreqhpl   = 2'b00;
      dreqaddr  = 32'h0;
      dreqdata  = 32'h0;
      drspready = 1'b1;
      mreqready = 1'b1;
      mrspvalid = 1'b0;
      mrsprerr  = 1'b0;
      mrspwerr  = 1'b0;
      mrspdata  = 32'h0;
   endtask

   initial begin
      // Reset: outputs stay quiet even with everything asserted
      idle();
      reset     = 1'b1;
      ireqvalid = 1'b1;
      dreqvalid = 1'b1;
      mrspvalid = 1'b1;
      cyc();
      cyc();
      chk("rst_ireqready", {31'b0, ireqready}, 32'd0);
      chk("rst_dreqready", {31'b0, dreqready}, 32'd0);
      chk("rst_mreqvalid", {31'b0, mreqvalid}, 32'd0);
      chk("rst_irspvalid", {31'b0, irspvalid}, 32'd0);
      chk("rst_drspvalid", {31'b0, drspvalid}, 32'd0);
      chk("rst_mrspready", {31'b0, mrspready}, 32'd0);
      idle();

      // 1: both valid every cycle -> D, I, D, I
      ireqvalid = 1'b1;
      ireqaddr  = 32'h200;
      dreqvalid = 1'b1;
      dreqwrite = 1'b1;
      dreqaddr  = 32'h100;
      dreqdata  = 32'hDEAD;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("alt_dreqready", {31'b0, dreqready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("alt_ireqready", {31'b0, ireqready}, (i % 2 == 0) ? 32'd0 : 32'd1);
         chk("alt_mreqaddr", mreqaddr, (i % 2 == 0) ? 32'h100 : 32'h200);
         if (i == 1) begin
            chk("i_mreqsize", {30'b0, mreqsize}, 32'd2);
            chk("i_mreqwrite", {31'b0, mreqwrite}, 32'd0);
            chk("i_mreqdata", mreqdata, 32'd0);
         end
         cyc();
      end
      ireqvalid = 1'b0;
      dreqvalid = 1'b0;
      mrspvalid = 1'b1;
      mrspdata  = 32'h11;
      #1;
      chk("alt_rsp0_irspvalid", {31'b0, irspvalid}, 32'd1);
      chk("alt_rsp0_drspvalid", {31'b0, drspvalid}, 32'd0);
      chk("alt_rsp0_irspdata", irspdata, 32'h11);
      chk("alt_rsp0_mrspready", {31'b0, mrspready}, 32'd1);
      cyc();
      mrspdata = 32'h22;
      #1;
      chk("alt_rsp1_irspvalid", {31'b0, irspvalid}, 32'd1);
      cyc();
      mrspvalid = 1'b0;

      // 2: lock on a stalled D, I arrives while locked
      dreqvalid = 1'b1;
      #1;
      chk("pre_lock_dreqready", {31'b0, dreqready}, 32'd1);
      cyc();
      mreqready = 1'b0;
      #1;
      chk("lock_mreqvalid", {31'b0, mreqvalid}, 32'd1);
      chk("lock_dreqready", {31'b0, dreqready}, 32'd0);
      cyc();
      ireqvalid = 1'b1;
      ireqaddr  = 32'h300;
      #1;
      chk("locked_mreqaddr", mreqaddr, 32'h100);
      chk("locked_ireqready", {31'b0, ireqready}, 32'd0);
      cyc();
      #1;
      chk("locked2_mreqaddr", mreqaddr, 32'h100);
      cyc();
      mreqready = 1'b1;
      #1;
      chk("unlock_dreqready", {31'b0, dreqready}, 32'd1);
      chk("unlock_ireqready", {31'b0, ireqready}, 32'd0);
      cyc();
      #1;
      chk("after_lock_ireqready", {31'b0, ireqready}, 32'd1);
      chk("after_lock_dreqready", {31'b0, dreqready}, 32'd0);
      chk("after_lock_mreqaddr", mreqaddr, 32'h300);
      cyc();
      ireqvalid = 1'b0;
      dreqvalid = 1'b0;
      mrspvalid = 1'b1;
      mrspdata  = 32'h55;
      #1;
      chk("lock_rsp_irspdata", irspdata, 32'h55);
      chk("lock_rsp_irspvalid", {31'b0, irspvalid}, 32'd1);
      cyc();
      mrspvalid = 1'b0;

      // 3: fill the order FIFO with I reads; D write still passes
      ireqvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ireqaddr = 32'h400 + 32'(i * 4);
         #1;
         chk("fill_ireqready", {31'b0, ireqready}, 32'd1);
         cyc();
      end
      #1;
      chk("full_mreqvalid", {31'b0, mreqvalid}, 32'd0);
      chk("full_ireqready", {31'b0, ireqready}, 32'd0);
      dreqvalid = 1'b1;
      dreqwrite = 1'b1;
      #1;
      chk("full_dwr_mreqvalid", {31'b0, mreqvalid}, 32'd1);
      chk("full_dwr_dreqready", {31'b0, dreqready}, 32'd1);
      chk("full_dwr_mreqwrite", {31'b0, mreqwrite}, 32'd1);
      cyc();
      ireqvalid = 1'b0;
      dreqvalid = 1'b0;
      mrspvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mrspdata = 32'h1000 + 32'(i);
         #1;
         chk("drain_irspvalid", {31'b0, irspvalid}, 32'd1);
         chk("drain_drspvalid", {31'b0, drspvalid}, 32'd0);
         chk("drain_irspdata", irspdata, 32'h1000 + 32'(i));
         cyc();
      end
      mrspvalid = 1'b0;

      // 4: I read, D read, I read; responses routed in order, then stall I
      ireqvalid = 1'b1;
      ireqaddr  = 32'h40;
      #1;
      chk("mix_i0_ireqready", {31'b0, ireqready}, 32'd1);
      cyc();
      ireqvalid = 1'b0;
      dreqvalid = 1'b1;
      dreqwrite = 1'b0;
      dreqsize  = 2'b00;
      dreqaddr  = 32'h500;
      #1;
      chk("mix_d_dreqready", {31'b0, dreqready}, 32'd1);
      chk("mix_d_mreqsize", {30'b0, mreqsize}, 32'd0);
      chk("mix_d_mreqwrite", {31'b0, mreqwrite}, 32'd0);
      cyc();
      dreqvalid = 1'b0;
      ireqvalid = 1'b1;
      #1;
      chk("mix_i1_ireqready", {31'b0, ireqready}, 32'd1);
      cyc();
      ireqvalid = 1'b0;
      mrspvalid = 1'b1;
      mrspdata  = 32'hA;
      #1;
      chk("mix_a_irspvalid", {31'b0, irspvalid}, 32'd1);
      chk("mix_a_drspvalid", {31'b0, drspvalid}, 32'd0);
      cyc();
      mrspdata = 32'hB;
      #1;
      chk("mix_b_drspvalid", {31'b0, drspvalid}, 32'd1);
      chk("mix_b_irspvalid", {31'b0, irspvalid}, 32'd0);
      chk("mix_b_drspdata", drspdata, 32'hB);
      cyc();
      mrspdata  = 32'hC;
      irspready = 1'b0;
      #1;
      chk("mix_c_stall_irspvalid", {31'b0, irspvalid}, 32'd1);
      chk("mix_c_stall_mrspready", {31'b0, mrspready}, 32'd0);
      cyc();
      irspready = 1'b1;
      #1;
      chk("mix_c_irspvalid", {31'b0, irspvalid}, 32'd1);
      chk("mix_c_mrspready", {31'b0, mrspready}, 32'd1);
      chk("mix_c_irspdata", irspdata, 32'hC);
      cyc();
      mrspvalid = 1'b0;

      // 5: write error goes to D while the head is I; head not popped
      ireqvalid = 1'b1;
      cyc();
      ireqvalid = 1'b0;
      mrspvalid = 1'b1;
      mrspwerr  = 1'b1;
      mrspdata  = 32'hEE;
      #1;
      chk("werr_drspvalid", {31'b0, drspvalid}, 32'd1);
      chk("werr_drspwerr", {31'b0, drspwerr}, 32'd1);
      chk("werr_irspvalid", {31'b0, irspvalid}, 32'd0);
      cyc();
      mrspwerr = 1'b0;
      mrspdata = 32'h77;
      #1;
      chk("post_werr_irspvalid", {31'b0, irspvalid}, 32'd1);
      chk("post_werr_drspvalid", {31'b0, drspvalid}, 32'd0);
      chk("post_werr_irspdata", irspdata, 32'h77);
      cyc();
      mrspvalid = 1'b0;

      // 6: reset while locked on I with two reads outstanding
      ireqvalid = 1'b1;
      ireqaddr  = 32'h600;
      cyc();
      cyc();
      mreqready = 1'b0;
      #1;
      chk("r6_lock_mreqvalid", {31'b0, mreqvalid}, 32'd1);
      cyc();
      dreqvalid = 1'b1;
      dreqwrite = 1'b1;
      dreqaddr  = 32'h700;
      #1;
      chk("r6_locked_mreqaddr", mreqaddr, 32'h600);
      reset = 1'b1;
      #1;
      chk("r6_rst_mreqvalid", {31'b0, mreqvalid}, 32'd0);
      chk("r6_rst_ireqready", {31'b0, ireqready}, 32'd0);
      chk("r6_rst_dreqready", {31'b0, dreqready}, 32'd0);
      cyc();
      reset     = 1'b0;
      mreqready = 1'b1;
      #1;
      chk("r6_tie_dreqready", {31'b0, dreqready}, 32'd1);
      chk("r6_tie_ireqready", {31'b0, ireqready}, 32'd0);
      cyc();
      dreqvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("r6_empty_ireqready", {31'b0, ireqready}, 32'd1);
         cyc();
      end
      #1;
      chk("r6_full_mreqvalid", {31'b0, mreqvalid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
